mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
Iterative multiply/divide unit for the MIPS execute stage. It consumes the two register-file read operands (rd1 → opa, rd2 → opb) and computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers. MTHI/MTLO write HI/LO directly. The HI/LO outputs feed the MFHI/MFLO writeback path. A start/busy/done handshake stalls the pipeline while an operation runs.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH each and the product is 2*WIDTH.
CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request; sampled only when busy=0
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
opa  input  WIDTH  rs operand (multiplicand / dividend)
opb  input  WIDTH  rt operand (multiplier / divisor)
mthi  input  1  write mt_data to HI
mtlo  input  1  write mt_data to LO
mt_data  input  WIDTH  MTHI/MTLO data
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
dz  output  1  divide-by-zero flag for the last completed operation

Behaviour:
- Reset (rst=0, any time, including mid-operation): hi=0, lo=0, busy=0, done=0, dz=0, state=IDLE, counter=0. Takes effect immediately. No partial result is kept.
- States: IDLE, CALC, FIX.
- IDLE with start=1:
  - Latch op.
  - For signed ops, latch |opa| and |opb| and record the result signs: product sign = sign(a)^sign(b); quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - Clear the accumulator, set counter=0, busy<=1, and go to CALC.
  - start has priority over mthi/mtlo in the same cycle; mthi/mtlo are dropped.
- IDLE with start=0: mthi writes HI and mtlo writes LO on that edge. If both are asserted, both registers take mt_data. dz is unchanged.
- CALC: exactly WIDTH cycles, one bit per cycle.
  - Multiply: shift-add on unsigned magnitudes.
  - Divide: restoring division on unsigned magnitudes.
  - Counter increments each cycle; go to FIX after the cycle with counter=WIDTH-1.
- FIX: one cycle.
  - Apply sign correction (two's-complement negate where the recorded sign is 1).
  - Write hi/lo, pulse done=1 for one cycle, set busy<=0, return to IDLE.
- Latency: if start is sampled at edge E0, hi/lo update and done rises at edge E(WIDTH+1) (E33 for WIDTH=32). busy is high from E0 until E(WIDTH+1), when it falls in the same edge that done rises.
- Multiply result: {hi,lo} = full 2*WIDTH product. MULT is a signed product; MULTU is an unsigned product.
- Divide result: lo = quotient, hi = remainder. Quotient truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero (opb=0, DIV or DIVU):
  - lo = all ones; hi = opa as latched (original signed value, not the magnitude).
  - dz=1 with done. Latency is unchanged.
- dz is 0 on completion of any other operation.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0, dz=0.
- While busy=1:
  - hi/lo hold their previous values until the FIX edge.
  - start, mthi and mtlo are ignored (no queuing).
  - opa/opb may change freely.
- start may be reasserted in the cycle done=1 (busy=0). It is accepted, and the next operation begins normally.
- done is never asserted without a preceding accepted start.

Test Plan:
- Reset, then MULTU opa=0xFFFFFFFF opb=0xFFFFFFFF → hi=0xFFFFFFFE lo=0x00000001 dz=0; done high exactly 33 cycles after the start edge; busy high for cycles 1..32.
- MULT opa=0xFFFFFFFD (-3) opb=5 → hi=0xFFFFFFFF lo=0xFFFFFFF1; then DIVU 100/7 → lo=14 hi=2.
- DIV opa=0xFFFFFFF9 (-7) opb=2 → lo=0xFFFFFFFD hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000 hi=0 dz=0.
- DIVU 5/0 → lo=0xFFFFFFFF hi=5 dz=1; a following MULTU 2*3 clears dz → hi=0 lo=6.
- During a busy operation, pulse start (op=MULTU, 1*1) and mthi with mt_data=0xDEAD → both ignored, hi/lo unchanged until done. In idle, mthi+mtlo with mt_data=0x1234 → hi=lo=0x1234. Same-cycle start+mtlo → mtlo dropped.
- Assert rst=0 at cycle 10 of a DIV → immediately busy=0 done=0 hi=0 lo=0; after release, no done pulse appears; a new MULTU 3*4 → lo=12.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit: signed/unsigned MULT and DIV into HI/LO,
// one bit per cycle over WIDTH cycles, followed by a sign-fix cycle.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [1:0]       dbg_state
);

  // Handshake: start is accepted only on an edge where busy=0; done pulses for
  // exactly one cycle when hi/lo take the result, on the same edge busy falls.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_mag, b_mag, a_raw;
  logic             neg_q, neg_r;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;

  // Operand magnitudes at start; op[0]=0 selects the signed variants
  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & opa[WIDTH-1];
    b_neg     = is_signed & opb[WIDTH-1];
    a_abs     = a_neg ? (~opa + 1'b1) : opa;
    b_abs     = b_neg ? (~opb + 1'b1) : opb;
  end

  // One shift-add step (multiply) and one restoring step (divide)
  logic [WIDTH:0]   mul_sum, div_shift, div_rem;
  logic [WIDTH-1:0] div_quo;
  logic             div_ge;

  always_comb begin
    mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, a_mag} : '0);
    div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_mag});
    div_rem   = div_ge ? (div_shift - {1'b0, b_mag}) : div_shift;
    div_quo   = {acc_lo[WIDTH-2:0], div_ge};
  end

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   rem_raw, quo_fix, rem_fix;

  always_comb begin
    prod     = {acc_hi[WIDTH-1:0], acc_lo};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    rem_raw  = acc_hi[WIDTH-1:0];
    quo_fix  = neg_q ? (~acc_lo + 1'b1) : acc_lo;
    rem_fix  = neg_r ? (~rem_raw + 1'b1) : rem_raw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      a_raw  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            a_raw  <= opa;
            a_mag  <= a_abs;
            b_mag  <= b_abs;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= op[1] ? a_abs : b_abs;
          end else begin
            if (mthi) hi <= mt_data;
            if (mtlo) lo <= mt_data;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_q[1]) begin
            acc_hi <= div_rem;
            acc_lo <= div_quo;
          end else begin
            acc_hi <= {1'b0, mul_sum[WIDTH:1]};
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (!op_q[1]) begin
            {hi, lo} <= prod_fix;
            dz       <= 1'b0;
          end else if (b_mag == '0) begin
            // Divide by zero reports the original dividend, not its magnitude
            hi <= a_raw;
            lo <= '1;
            dz <= 1'b1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
            dz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed MIPS cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_mdu_iter;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] opa, opb, mt_data;
  logic [W-1:0] hi, lo;
  logic         busy, done, dz;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad = 0;

  mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .dz(dz), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: {dz, hi, lo} from MIPS arithmetic rules
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint     sa, sb, p, q, r;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin p = sa * sb; return {1'b0, p[63:0]}; end
      2'd1: begin pu = {32'd0, a} * {32'd0, b}; return {1'b0, pu}; end
      2'd2: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Issues one op at #1 after an edge and waits for done; reports latency and
  // whether busy stayed high and hi/lo held until completion.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int cyc, output logic held);
    logic [W-1:0] h0, l0;
    h0 = hi; l0 = lo; held = 1'b1;
    op = o; opa = a; opb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    opa = $urandom; opb = $urandom;
    cyc = 0;
    if (!busy || hi !== h0 || lo !== l0) held = 1'b0;
    while (cyc < LAT + 8) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
      if (!busy || hi !== h0 || lo !== l0) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 0; mthi = 0; mtlo = 0; op = 0; opa = 0; opb = 0; mt_data = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({hi, lo, busy, done, dz} !== '0) begin
      bad++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b, need all zero", hi, lo, busy, done, dz);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu_max();
    int cyc; logic held;
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, held);
    total++;
    if (cyc !== LAT || !held || busy !== 1'b0) begin
      bad++;
      $display("FAIL multu_max_timing: cyc=%0d held=%b busy=%b, need %0d 1 0", cyc, held, busy, LAT);
    end
    total++;
    if ({dz, hi, lo} !== {1'b0, 32'hFFFF_FFFE, 32'h0000_0001}) begin
      bad++;
      $display("FAIL multu_max: dz=%b hi=%h lo=%h, need 0 fffffffe 00000001", dz, hi, lo);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_width: done=%b one cycle later, need 0", done);
    end
  endtask

  task automatic test_mult_divu();
    int cyc; logic held;
    run_op(2'd0, 32'hFFFF_FFFD, 32'd5, cyc, held);
    total++;
    if (cyc !== LAT || !held || {dz, hi, lo} !== {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1}) begin
      bad++;
      $display("FAIL mult_neg: cyc=%0d held=%b dz=%b hi=%h lo=%h, need ffffffff fffffff1", cyc, held, dz, hi, lo);
    end
    @(posedge clk); #1;
    run_op(2'd3, 32'd100, 32'd7, cyc, held);
    total++;
    if (cyc !== LAT || !held || {dz, hi, lo} !== {1'b0, 32'd2, 32'd14}) begin
      bad++;
      $display("FAIL divu_100_7: cyc=%0d held=%b dz=%b hi=%h lo=%h, need hi=2 lo=14", cyc, held, dz, hi, lo);
    end
  endtask

  task automatic test_div_signed();
    int cyc; logic held;
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, cyc, held);
    total++;
    if (cyc !== LAT || {dz, hi, lo} !== {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      bad++;
      $display("FAIL div_neg7_2: cyc=%0d dz=%b hi=%h lo=%h, need hi=ffffffff lo=fffffffd", cyc, dz, hi, lo);
    end
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc, held);
    total++;
    if (cyc !== LAT || {dz, hi, lo} !== {1'b0, 32'h0, 32'h8000_0000}) begin
      bad++;
      $display("FAIL div_overflow: cyc=%0d dz=%b hi=%h lo=%h, need hi=0 lo=80000000 dz=0", cyc, dz, hi, lo);
    end
  endtask

  task automatic test_div_zero();
    int cyc; logic held;
    run_op(2'd3, 32'd5, 32'd0, cyc, held);
    total++;
    if (cyc !== LAT || {dz, hi, lo} !== {1'b1, 32'd5, 32'hFFFF_FFFF}) begin
      bad++;
      $display("FAIL divu_zero: cyc=%0d dz=%b hi=%h lo=%h, need dz=1 hi=5 lo=ffffffff", cyc, dz, hi, lo);
    end
    run_op(2'd2, 32'hFFFF_FFF0, 32'd0, cyc, held);
    total++;
    if (cyc !== LAT || {dz, hi, lo} !== {1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF}) begin
      bad++;
      $display("FAIL div_zero_signed: dz=%b hi=%h lo=%h, need dz=1 hi=fffffff0 lo=ffffffff", dz, hi, lo);
    end
    @(posedge clk); #1;
    mthi = 1'b1; mt_data = 32'h42;
    @(posedge clk); #1;
    mthi = 1'b0;
    total++;
    if ({dz, hi, lo} !== {1'b1, 32'h42, 32'hFFFF_FFFF}) begin
      bad++;
      $display("FAIL mthi_keeps_dz: dz=%b hi=%h lo=%h, need dz=1 hi=42 lo=ffffffff", dz, hi, lo);
    end
    run_op(2'd1, 32'd2, 32'd3, cyc, held);
    total++;
    if ({dz, hi, lo} !== {1'b0, 32'd0, 32'd6}) begin
      bad++;
      $display("FAIL multu_clears_dz: dz=%b hi=%h lo=%h, need dz=0 hi=0 lo=6", dz, hi, lo);
    end
  endtask

  task automatic test_ignore_busy();
    int cyc, extra; logic held;
    logic [W-1:0] h0, l0;
    @(posedge clk); #1;
    h0 = hi; l0 = lo; held = 1'b1;
    op = 2'd3; opa = 32'd100; opb = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < LAT + 8) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
      if (!busy || hi !== h0 || lo !== l0) held = 1'b0;
      if (cyc == 5) begin
        start = 1'b1; op = 2'd1; opa = 32'd1; opb = 32'd1; mthi = 1'b1; mt_data = 32'hDEAD;
      end else begin
        start = 1'b0; mthi = 1'b0; opa = $urandom; opb = $urandom;
      end
    end
    start = 1'b0; mthi = 1'b0;
    total++;
    if (cyc !== LAT || !held || {dz, hi, lo} !== {1'b0, 32'd2, 32'd14}) begin
      bad++;
      $display("FAIL busy_ignore: cyc=%0d held=%b hi=%h lo=%h, need %0d 1 hi=2 lo=14", cyc, held, hi, lo, LAT);
    end
    extra = 0;
    repeat (LAT + 4) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL busy_no_queue: %0d busy/done cycles after completion, need 0", extra);
    end
  endtask

  task automatic test_mt();
    int cyc; logic held;
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h1234;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    total++;
    if ({hi, lo} !== {32'h1234, 32'h1234}) begin
      bad++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h, need 1234 1234", hi, lo);
    end
    mtlo = 1'b1; mt_data = 32'h5555;
    run_op(2'd1, 32'd2, 32'd3, cyc, held);
    total++;
    if (!held || cyc !== LAT || {dz, hi, lo} !== {1'b0, 32'd0, 32'd6}) begin
      bad++;
      $display("FAIL start_beats_mtlo: held=%b cyc=%0d hi=%h lo=%h, need held=1 hi=0 lo=6", held, cyc, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2; logic held1, held2;
    run_op(2'd0, 32'h0001_0000, 32'hFFFF_0000, cyc1, held1);
    run_op(2'd3, 32'd1000, 32'd33, cyc2, held2);
    total++;
    if (cyc1 !== LAT || cyc2 !== LAT || !held2 || {dz, hi, lo} !== {1'b0, 32'd10, 32'd30}) begin
      bad++;
      $display("FAIL back_to_back: cyc=%0d/%0d held=%b hi=%h lo=%h, need hi=a lo=1e", cyc1, cyc2, held2, hi, lo);
    end
  endtask

  task automatic test_random();
    int cyc; logic held;
    logic [1:0] o; logic [W-1:0] a, b;
    logic [2*W:0] exp;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      exp = model(o, a, b);
      run_op(o, a, b, cyc, held);
      total++;
      if (cyc !== LAT || !held || {dz, hi, lo} !== exp) begin
        bad++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: cyc=%0d held=%b got %b/%h/%h, need %b/%h/%h",
                 i, o, a, b, cyc, held, dz, hi, lo, exp[2*W], exp[2*W-1:W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, stray; logic held;
    @(posedge clk); #1;
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h77;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    op = 2'd2; opa = 32'hFFFF_FFF9; opb = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({busy, done, hi, lo} !== '0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, need all zero", busy, done, hi, lo);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    stray = 0;
    repeat (LAT + 5) begin
      @(posedge clk); #1;
      if (done || busy) stray++;
    end
    total++;
    if (stray !== 0) begin
      bad++;
      $display("FAIL reset_no_done: %0d busy/done cycles after reset, need 0", stray);
    end
    run_op(2'd1, 32'd3, 32'd4, cyc, held);
    total++;
    if (cyc !== LAT || {dz, hi, lo} !== {1'b0, 32'd0, 32'd12}) begin
      bad++;
      $display("FAIL after_reset_multu: cyc=%0d hi=%h lo=%h, need hi=0 lo=12", cyc, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_mult_divu();
    test_div_signed();
    test_div_zero();
    test_ignore_busy();
    test_mt();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
